// File: rtl/pe_incha_multi.sv
// pe_incha_multi: NUM_MACC-lane input-channel PE with Q8.8 requantisation; `define PE_SAT_FLAG_EN adds o_sat
module pe_incha_multi #(
    parameter int IN_CHANNEL  = 2,
    parameter int OUT_CHANNEL = 4,
    parameter int KERNEL_0    = 3,
    parameter int KERNEL_1    = 3,
    parameter int NUM_MACC    = 2,
    parameter     OUTPUT_MODE = "relu",
    localparam int N  = IN_CHANNEL * KERNEL_0 * KERNEL_1,
    localparam int OW = (OUTPUT_MODE == "relu") ? 8 : 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [8*N-1:0]            i_data,
    input  logic                      i_valid,
    output logic                      pe_ready,
    output logic                      pe_ack,
    output logic [OW*OUT_CHANNEL-1:0] o_data,
    output logic                      o_valid,
    input  logic                      o_ready,
    input  logic                      weight_wr_en,
    input  logic [31:0]               weight_wr_addr,
    input  logic [15:0]               weight_wr_data
`ifdef PE_SAT_FLAG_EN
    ,
    output logic [OUT_CHANNEL-1:0]    o_sat
`endif
);
    localparam int  G    = OUT_CHANNEL / NUM_MACC;
    localparam bit  RELU = (OUTPUT_MODE == "relu");
    localparam int  KW   = (N > 1) ? $clog2(N) : 1;
    localparam int  GW   = (G > 1) ? $clog2(G) : 1;
    localparam int  CW   = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1;
    localparam int  AW   = 16 + $clog2(N);
    localparam int  YW   = AW + 18;
    localparam logic signed [YW-1:0] HI = RELU ? 127 : 32767;
    localparam logic signed [YW-1:0] LO = RELU ? 0 : -32768;

    typedef enum logic [1:0] {IDLE, MACC, POST, OUT} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [GW-1:0]          g_q, g_d;
    logic signed [AW-1:0]   acc_q [NUM_MACC];
    logic signed [AW-1:0]   acc_d [NUM_MACC];
    logic signed [7:0]      x_q [N];
    logic signed [7:0]      x_d [N];
    logic [OW-1:0]          obuf_q [OUT_CHANNEL];
    logic [OW-1:0]          obuf_d [OUT_CHANNEL];
    logic signed [15:0]     coeff_q, coeff_d;
`ifdef PE_SAT_FLAG_EN
    logic [OUT_CHANNEL-1:0] sat_q, sat_d;
    logic                   clip [NUM_MACC];
`endif

    logic signed [7:0]      kern_mem [OUT_CHANNEL][N];
    logic signed [15:0]     bias_mem [OUT_CHANNEL];

    logic [7:0]             wr_type, wr_ch, wr_pos;
    logic                   wr_ok, kern_we, bias_we;
    logic [CW-1:0]          lane_ch [NUM_MACC];
    logic signed [15:0]     prod [NUM_MACC];
    logic [OW-1:0]          res [NUM_MACC];
    logic                   unused_addr;

    assign wr_type     = weight_wr_addr[31:24];
    assign wr_ch       = weight_wr_addr[23:16];
    assign wr_pos      = weight_wr_addr[15:8];
    assign unused_addr = ^weight_wr_addr[7:0];
    assign wr_ok       = weight_wr_en && state_q == IDLE;
    assign kern_we     = wr_ok && wr_type == 8'd0 && 32'(wr_ch) < OUT_CHANNEL && 32'(wr_pos) < N;
    assign bias_we     = wr_ok && wr_type == 8'd1 && 32'(wr_ch) < OUT_CHANNEL;
    assign coeff_d     = (wr_ok && wr_type == 8'd2) ? weight_wr_data : coeff_q;

    assign pe_ready = state_q == IDLE;
    assign pe_ack   = pe_ready && i_valid;
    assign o_valid  = state_q == OUT;
`ifdef PE_SAT_FLAG_EN
    assign o_sat    = sat_q;
`endif

    // Weight and bias storage: written only while idle, never reset
    always_ff @(posedge clk) begin
        if (kern_we) kern_mem[wr_ch[CW-1:0]][wr_pos[KW-1:0]] <= weight_wr_data[7:0];
        if (bias_we) bias_mem[wr_ch[CW-1:0]] <= weight_wr_data;
    end

    // Per-lane datapath: MAC product and requantised, clamped result of the current group
    always_comb begin : lane_dp
        logic signed [YW-1:0] y, r;
        for (int l = 0; l < NUM_MACC; l++) begin
            lane_ch[l] = CW'(int'(g_q) * NUM_MACC + l);
            prod[l]    = kern_mem[lane_ch[l]][k_q] * x_q[k_q];
            y          = YW'(acc_q[l]) * YW'(coeff_q) + (YW'(bias_mem[lane_ch[l]]) <<< 8);
            r          = (y + YW'(128)) >>> 8;
            res[l]     = (r > HI) ? OW'(HI) : (r < LO) ? OW'(LO) : OW'(r);
`ifdef PE_SAT_FLAG_EN
            clip[l]    = (r > HI) || (!RELU && r < LO);
`endif
        end
    end

    // Control FSM: accept window, sweep groups through MACC/POST, hold result in OUT
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        g_d     = g_q;
        acc_d   = acc_q;
        x_d     = x_q;
        obuf_d  = obuf_q;
`ifdef PE_SAT_FLAG_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            IDLE: if (i_valid) begin
                for (int p = 0; p < N; p++) x_d[p] = i_data[8*p +: 8];
                for (int l = 0; l < NUM_MACC; l++) acc_d[l] = '0;
                k_d     = '0;
                g_d     = '0;
                state_d = MACC;
            end
            MACC: begin
                for (int l = 0; l < NUM_MACC; l++) acc_d[l] = acc_q[l] + AW'(prod[l]);
                k_d     = k_q + 1'b1;
                state_d = (k_q == KW'(N - 1)) ? POST : MACC;
            end
            POST: begin
                for (int l = 0; l < NUM_MACC; l++) begin
                    obuf_d[lane_ch[l]] = res[l];
`ifdef PE_SAT_FLAG_EN
                    sat_d[lane_ch[l]]  = clip[l];
`endif
                end
                if (g_q == GW'(G - 1)) begin
                    state_d = OUT;
                end else begin
                    for (int l = 0; l < NUM_MACC; l++) acc_d[l] = '0;
                    g_d     = g_q + 1'b1;
                    k_d     = '0;
                    state_d = MACC;
                end
            end
            OUT: state_d = o_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            g_q     <= '0;
            coeff_q <= 16'sh0100;
            for (int l = 0; l < NUM_MACC; l++) acc_q[l] <= '0;
            for (int p = 0; p < N; p++) x_q[p] <= '0;
            for (int c = 0; c < OUT_CHANNEL; c++) obuf_q[c] <= '0;
`ifdef PE_SAT_FLAG_EN
            sat_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            g_q     <= g_d;
            coeff_q <= coeff_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            obuf_q  <= obuf_d;
`ifdef PE_SAT_FLAG_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // Flatten the output buffer onto o_data
    always_comb begin
        for (int c = 0; c < OUT_CHANNEL; c++) o_data[OW*c +: OW] = obuf_q[c];
    end
endmodule
